// File: rtl/rfsoc_axil_pkg.sv
// Shared types and constants for the RFSoC AXI4-Lite register front-end.
package rfsoc_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_EXEC = 3'd3,
    RD_RESP = 3'd4
  } axil_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [15:0] REG_MAX_OFFSET  = 16'h0114;

  // Register file is word addressed; byte lanes are carried by the strobes.
  function automatic logic [15:0] to_word_offset(input logic [15:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

endpackage

// File: rtl/rfsoc_axil_slave.sv
// AXI4-Lite slave to flat register-bus bridge, one transaction at a time, writes before reads.
// Define RFSOC_AXIL_SLVERR_EN to answer accesses beyond MAX_OFFSET with SLVERR.
import rfsoc_axil_pkg::*;

module rfsoc_axil_slave #(
  parameter int          ADDR_W     = 16,
  parameter logic [15:0] MAX_OFFSET = REG_MAX_OFFSET
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              reg_wren,
  output logic [15:0]       reg_offset,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  input  logic [31:0]       reg_rdata
);

`ifdef RFSOC_AXIL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  axil_state_e r_state, w_state_nxt;

  logic        r_aw_held, r_w_held;
  logic [15:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_rd_err;

  logic        r_reg_wren;
  logic [15:0] r_reg_offset;
  logic [31:0] r_reg_wdata;
  logic [3:0]  r_reg_wstrb;
  logic [31:0] r_rdata;
  logic [1:0]  r_bresp, r_rresp;

  logic        w_idle, w_aw_hs, w_w_hs, w_ar_hs, w_wr_go;
  logic [15:0] w_wr_off, w_rd_off;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_err, w_rd_err;

  assign w_idle = (r_state == IDLE);

  // Readies are gated by rstb so nothing is accepted while reset is held.
  assign s_axil_awready = rstb && w_idle && !r_aw_held;
  assign s_axil_wready  = rstb && w_idle && !r_w_held;
  assign s_axil_arready = rstb && w_idle && !r_aw_held && !r_w_held
                          && !s_axil_awvalid && !s_axil_wvalid;

  assign w_aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_w_hs  = s_axil_wvalid  && s_axil_wready;
  assign w_ar_hs = s_axil_arvalid && s_axil_arready;
  assign w_wr_go = w_idle && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // A half captured in this same cycle bypasses its holding register.
  assign w_wr_off  = to_word_offset(r_aw_held ? r_awaddr : s_axil_awaddr[15:0]);
  assign w_wr_data = r_w_held ? r_wdata : s_axil_wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : s_axil_wstrb;
  assign w_rd_off  = to_word_offset(s_axil_araddr[15:0]);

  assign w_wr_err = SLVERR_EN && (w_wr_off > MAX_OFFSET);
  assign w_rd_err = SLVERR_EN && (w_rd_off > MAX_OFFSET);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_go)      w_state_nxt = WR_EXEC;
        else if (w_ar_hs) w_state_nxt = RD_EXEC;
      end
      WR_EXEC: w_state_nxt = WR_RESP;
      WR_RESP: if (s_axil_bready) w_state_nxt = IDLE;
      RD_EXEC: w_state_nxt = RD_RESP;
      RD_RESP: if (s_axil_rready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state      <= IDLE;
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_rd_err     <= 1'b0;
      r_reg_wren   <= 1'b0;
      r_reg_offset <= '0;
      r_reg_wdata  <= '0;
      r_reg_wstrb  <= '0;
      r_rdata      <= '0;
      r_bresp      <= AXI_RESP_OKAY;
      r_rresp      <= AXI_RESP_OKAY;
    end else begin
      r_state    <= w_state_nxt;
      r_reg_wren <= 1'b0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil_awaddr[15:0];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end
      if (w_wr_go) begin
        r_aw_held    <= 1'b0;
        r_w_held     <= 1'b0;
        r_reg_wren   <= !w_wr_err;
        r_reg_offset <= w_wr_off;
        r_reg_wdata  <= w_wr_data;
        r_reg_wstrb  <= w_wr_strb;
        r_bresp      <= w_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (w_ar_hs) begin
        r_reg_offset <= w_rd_off;
        r_rd_err     <= w_rd_err;
      end
      if (r_state == RD_EXEC) begin
        r_rdata <= r_rd_err ? 32'h0 : reg_rdata;
        r_rresp <= r_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  assign s_axil_bvalid = (r_state == WR_RESP);
  assign s_axil_rvalid = (r_state == RD_RESP);
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_rdata  = r_rdata;
  assign reg_wren      = r_reg_wren;
  assign reg_offset    = r_reg_offset;
  assign reg_wdata     = r_reg_wdata;
  assign reg_wstrb     = r_reg_wstrb;

endmodule
